// File: rtl/slm_line_sequencer_if.sv
// slm_line_sequencer_if
// Groups the two data-path buses of the line sequencer: the line-buffer read
// side (occupancy, read data, pop strobe) and the SLM output side (word,
// valid, line start).
//   master : the sequencer (pops the buffer, drives the SLM bus)
//   slave  : the environment (buffer + SLM sink)
interface slm_line_sequencer_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        num_words_in_buffer;
  logic [DATA_W-1:0] buf_data_i;
  logic              buf_rd_en_o;
  logic [DATA_W-1:0] slm_data_o;
  logic              slm_valid_o;
  logic              slm_line_start_o;

  modport master (
    input  num_words_in_buffer, buf_data_i,
    output buf_rd_en_o, slm_data_o, slm_valid_o, slm_line_start_o
  );

  modport slave (
    output num_words_in_buffer, buf_data_i,
    input  buf_rd_en_o, slm_data_o, slm_valid_o, slm_line_start_o
  );
endinterface

// File: rtl/slm_line_sequencer.sv
// slm_line_sequencer
// Streams a frame of LINES_PER_FRAME lines from a line buffer to an SLM.
// Each line is popped as one uninterrupted burst of WORDS_PER_LINE reads,
// started only once the buffer already holds a full line, so the burst can
// never run the buffer dry.
// Ports:
//   fpga_clk         : clock, all state changes on the rising edge
//   reset_all_n      : asynchronous active-low reset
//   enable_i         : allows a new frame to start (looked at in IDLE only)
//   next_frame_rdy_i : timing controller says the next frame may begin
//   abort_i          : abandon the current frame, back to IDLE next edge
//   bus              : buffer read side + SLM output side (master modport)
//   line_done_o      : one-cycle pulse after the last word of a line
//   frame_done_o     : one-cycle pulse after the last line of a frame
//   line_count_o     : index of the line being sent
//   busy_o           : high whenever not IDLE
module slm_line_sequencer #(
  parameter int WORDS_PER_LINE  = 16,
  parameter int LINES_PER_FRAME = 1024,
  parameter int DATA_W          = 32
) (
  input  logic                 fpga_clk,
  input  logic                 reset_all_n,
  input  logic                 enable_i,
  input  logic                 next_frame_rdy_i,
  input  logic                 abort_i,
  slm_line_sequencer_if.master bus,
  output logic                 line_done_o,
  output logic                 frame_done_o,
  output logic [11:0]          line_count_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LINE,
    READ,
    LINE_END,
    FRAME_END
  } state_t;

  localparam logic [4:0]  LINE_WORDS = 5'(WORDS_PER_LINE);
  localparam logic [4:0]  LAST_WORD  = 5'(WORDS_PER_LINE - 1);
  localparam logic [11:0] LAST_LINE  = 12'(LINES_PER_FRAME - 1);

  state_t     state;
  logic [4:0] word_cnt;

  always_ff @(posedge fpga_clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      state                <= IDLE;
      word_cnt             <= 5'd0;
      bus.buf_rd_en_o      <= 1'b0;
      bus.slm_data_o       <= {DATA_W{1'b0}};
      bus.slm_valid_o      <= 1'b0;
      bus.slm_line_start_o <= 1'b0;
      line_done_o          <= 1'b0;
      frame_done_o         <= 1'b0;
      line_count_o         <= 12'd0;
      busy_o               <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register here sees the
      // pre-edge value of every other one regardless of statement order.
      // The output stage trails the read strobe by one cycle independent of
      // the state, which is what lets a word popped on the abort cycle still
      // reach the SLM.
      bus.slm_valid_o      <= bus.buf_rd_en_o;
      bus.slm_line_start_o <= bus.buf_rd_en_o && (word_cnt == 5'd0);
      if (bus.buf_rd_en_o) begin
        bus.slm_data_o <= bus.buf_data_i;
      end

      // NOTE: pulses default low here and are raised further down; the later
      // non-blocking assignment in the same edge wins.
      line_done_o  <= 1'b0;
      frame_done_o <= 1'b0;

      if (abort_i && (state != IDLE)) begin
        state           <= IDLE;
        bus.buf_rd_en_o <= 1'b0;
        busy_o          <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (enable_i && next_frame_rdy_i) begin
              state        <= WAIT_LINE;
              line_count_o <= 12'd0;
              busy_o       <= 1'b1;
            end
          end
          WAIT_LINE: begin
            // A whole line must be buffered before the burst starts.
            if (bus.num_words_in_buffer >= LINE_WORDS) begin
              state           <= READ;
              word_cnt        <= 5'd0;
              bus.buf_rd_en_o <= 1'b1;
            end
          end
          READ: begin
            if (word_cnt == LAST_WORD) begin
              state           <= LINE_END;
              bus.buf_rd_en_o <= 1'b0;
              line_done_o     <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 5'd1;
            end
          end
          LINE_END: begin
            if (line_count_o == LAST_LINE) begin
              state        <= FRAME_END;
              frame_done_o <= 1'b1;
            end else begin
              state        <= WAIT_LINE;
              line_count_o <= line_count_o + 12'd1;
            end
          end
          FRAME_END: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state           <= IDLE;
            bus.buf_rd_en_o <= 1'b0;
            busy_o          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slm_line_sequencer.sv
// tb_slm_line_sequencer
// Self-checking bench for slm_line_sequencer with WORDS_PER_LINE=4,
// LINES_PER_FRAME=3. A line-buffer model supplies occupancy and data, a
// negedge monitor records what the SLM side produced, and each test task
// compares the recorded activity with what a frame must look like.
module tb_slm_line_sequencer;
  localparam int W  = 4;
  localparam int L  = 3;
  localparam int DW = 32;

  logic        fpga_clk         = 1'b0;
  logic        reset_all_n      = 1'b0;
  logic        enable_i         = 1'b0;
  logic        next_frame_rdy_i = 1'b0;
  logic        abort_i          = 1'b0;
  logic        line_done_o;
  logic        frame_done_o;
  logic        busy_o;
  logic [11:0] line_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  slm_line_sequencer_if #(.DATA_W(DW)) bus ();

  slm_line_sequencer #(
    .WORDS_PER_LINE (W),
    .LINES_PER_FRAME(L),
    .DATA_W         (DW)
  ) dut (
    .fpga_clk        (fpga_clk),
    .reset_all_n     (reset_all_n),
    .enable_i        (enable_i),
    .next_frame_rdy_i(next_frame_rdy_i),
    .abort_i         (abort_i),
    .bus             (bus),
    .line_done_o     (line_done_o),
    .frame_done_o    (frame_done_o),
    .line_count_o    (line_count_o),
    .busy_o          (busy_o)
  );

  always #5 fpga_clk = ~fpga_clk;

  // ---------------- line-buffer model ----------------
  // In hold mode occupancy stays at occ_base; otherwise it is a real FIFO
  // count: occ_base plus random producer pushes minus pops. Data is an
  // incrementing sequence from word_base, one step per pop.
  int          occ_base   = 0;
  bit          hold_occ   = 1'b1;
  bit          refill     = 1'b0;
  logic [DW-1:0] word_base = '0;
  int          epoch      = 0;
  int          seen_epoch = 0;
  int          pushes     = 0;
  int          pops       = 0;
  bit          pop_pending = 1'b0;
  int          occ;

  assign occ = hold_occ ? occ_base : occ_base + pushes - pops;
  assign bus.num_words_in_buffer = 5'(occ);
  assign bus.buf_data_i = word_base + DW'(pops);

  always @(posedge fpga_clk) begin
    #2;
    if (seen_epoch != epoch) begin
      pushes     = 0;
      pops       = 0;
      seen_epoch = epoch;
    end else begin
      if (pop_pending && reset_all_n) pops++;
      if (refill && (occ_base + pushes - pops) < 31 && $urandom_range(2) == 0) pushes++;
    end
  end

  // ---------------- monitor ----------------
  int          mon_clear = 0;
  int          mon_seen  = 0;
  int          cyc = 0;
  int          n_rd, n_ld, n_fd, n_ls, n_ls_bad, n_ld_nov, n_gate_bad, n_empty_rd;
  logic [DW-1:0] out_q[$];
  int          out_cyc[$];
  logic [11:0] lc_q[$];
  int          fd_cyc_q[$];
  int          rd_rise_q[$];
  bit          prev_rd = 1'b0;
  bit          prev_valid = 1'b0;
  int          prev_occ = 0;

  always @(negedge fpga_clk) begin
    cyc++;
    if (mon_seen != mon_clear) begin
      mon_seen = mon_clear;
      n_rd = 0; n_ld = 0; n_fd = 0; n_ls = 0;
      n_ls_bad = 0; n_ld_nov = 0; n_gate_bad = 0; n_empty_rd = 0;
      out_q.delete(); out_cyc.delete(); lc_q.delete();
      fd_cyc_q.delete(); rd_rise_q.delete();
    end
    if (reset_all_n) begin
      if (bus.buf_rd_en_o) begin
        n_rd++;
        if (occ == 0) n_empty_rd++;
        if (!prev_rd) begin
          rd_rise_q.push_back(cyc);
          if (prev_occ < W) n_gate_bad++;
        end
      end
      if (bus.slm_valid_o) begin
        out_q.push_back(bus.slm_data_o);
        out_cyc.push_back(cyc);
      end
      if (bus.slm_line_start_o) n_ls++;
      if (bus.slm_line_start_o !== (bus.slm_valid_o && !prev_valid)) n_ls_bad++;
      if (line_done_o) begin
        n_ld++;
        lc_q.push_back(line_count_o);
        if (!bus.slm_valid_o) n_ld_nov++;
      end
      if (frame_done_o) begin
        n_fd++;
        fd_cyc_q.push_back(cyc);
      end
    end
    prev_rd     = bus.buf_rd_en_o;
    prev_valid  = bus.slm_valid_o;
    prev_occ    = occ;
    pop_pending = bus.buf_rd_en_o;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge fpga_clk);
    #1;
  endtask

  task automatic start_frame();
    epoch++;
    mon_clear++;
    enable_i         = 1'b1;
    next_frame_rdy_i = 1'b1;
    tick();
    enable_i         = 1'b0;
    next_frame_rdy_i = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      sample();
      ok = (n_fd >= target);
    end
  endtask

  task automatic wait_read_on_line(input logic [11:0] line, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      sample();
      found = bus.buf_rd_en_o && (line_count_o == line);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW+18:0] outs;
    occ_base = 0;
    enable_i = 1'b1;
    next_frame_rdy_i = 1'b1;
    repeat (3) sample();
    outs = {bus.buf_rd_en_o, bus.slm_valid_o, bus.slm_line_start_o, line_done_o,
            frame_done_o, busy_o, line_count_o, bus.slm_data_o};
    n_checks++; if (outs !== '0) $display("FAIL reset_outputs: got %0h expected 0", outs); else n_pass++;
    tick();
    reset_all_n = 1'b1;
    sample();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_release_before_edge busy: got %b expected 0", busy_o); else n_pass++;
    sample();
    n_checks++; if (busy_o !== 1'b1) $display("FAIL reset_release_first_edge busy: got %b expected 1", busy_o); else n_pass++;
    n_checks++; if (bus.buf_rd_en_o !== 1'b0) $display("FAIL reset_empty_buffer rd_en: got %b expected 0", bus.buf_rd_en_o); else n_pass++;
    enable_i = 1'b0;
    next_frame_rdy_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    sample();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL abort_wait_line busy: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_full_frame();
    bit ok;
    tick();
    hold_occ = 1'b1; refill = 1'b0; occ_base = 8;
    word_base = $urandom;
    start_frame();
    wait_fd(1, 80, ok);
    n_checks++; if (!ok) $display("FAIL full_frame timeout: got no frame_done expected one"); else n_pass++;
    n_checks++; if (n_rd !== L * W) $display("FAIL full_frame reads: got %0d expected %0d", n_rd, L * W); else n_pass++;
    n_checks++; if (n_ld !== L) $display("FAIL full_frame line_done: got %0d expected %0d", n_ld, L); else n_pass++;
    n_checks++; if (n_fd !== 1) $display("FAIL full_frame frame_done: got %0d expected 1", n_fd); else n_pass++;
    n_checks++; if (n_ls !== L || n_ls_bad !== 0) $display("FAIL full_frame line_start: got %0d (misplaced %0d) expected %0d", n_ls, n_ls_bad, L); else n_pass++;
    n_checks++; if (n_ld_nov !== 0) $display("FAIL full_frame last_valid_with_line_done: got %0d misses expected 0", n_ld_nov); else n_pass++;
    n_checks++; if (lc_q.size() !== L) $display("FAIL full_frame line_count_samples: got %0d expected %0d", lc_q.size(), L); else n_pass++;
    for (int i = 0; i < lc_q.size() && i < L; i++) begin
      n_checks++; if (lc_q[i] !== 12'(i)) $display("FAIL full_frame line_count[%0d]: got %0d expected %0d", i, lc_q[i], i); else n_pass++;
    end
    n_checks++; if (out_q.size() !== L * W) $display("FAIL full_frame words_out: got %0d expected %0d", out_q.size(), L * W); else n_pass++;
    for (int i = 0; i < out_q.size() && i < L * W; i++) begin
      n_checks++; if (out_q[i] !== word_base + DW'(i)) $display("FAIL full_frame data[%0d]: got %0h expected %0h", i, out_q[i], word_base + DW'(i)); else n_pass++;
    end
    sample();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL full_frame busy_after: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if (line_count_o !== 12'(L - 1)) $display("FAIL full_frame line_count_hold: got %0d expected %0d", line_count_o, L - 1); else n_pass++;
  endtask

  task automatic test_starvation();
    bit ok;
    tick();
    hold_occ = 1'b1; occ_base = W - 1;
    start_frame();
    repeat (20) sample();
    n_checks++; if (n_rd !== 0) $display("FAIL starve reads: got %0d expected 0", n_rd); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL starve busy: got %b expected 1", busy_o); else n_pass++;
    tick();
    occ_base = W;
    sample();
    n_checks++; if (bus.buf_rd_en_o !== 1'b0) $display("FAIL starve same_cycle rd_en: got %b expected 0", bus.buf_rd_en_o); else n_pass++;
    sample();
    n_checks++; if (bus.buf_rd_en_o !== 1'b1) $display("FAIL starve next_cycle rd_en: got %b expected 1", bus.buf_rd_en_o); else n_pass++;
    wait_fd(1, 80, ok);
    n_checks++; if (!ok || n_rd !== L * W) $display("FAIL starve completion: got done=%0d reads=%0d expected done=1 reads=%0d", ok, n_rd, L * W); else n_pass++;
  endtask

  task automatic test_datapath();
    bit ok;
    tick();
    hold_occ = 1'b1; occ_base = W;
    word_base = 32'h0000_00A0;
    start_frame();
    wait_fd(1, 80, ok);
    n_checks++; if (out_q.size() < W) $display("FAIL datapath words: got %0d expected >= %0d", out_q.size(), W); else n_pass++;
    for (int i = 0; i < W && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== 32'hA0 + DW'(i)) $display("FAIL datapath data[%0d]: got %0h expected %0h", i, out_q[i], 32'hA0 + DW'(i)); else n_pass++;
    end
    if (out_cyc.size() >= W) begin
      n_checks++; if (out_cyc[W-1] - out_cyc[0] !== W - 1) $display("FAIL datapath consecutive: got span %0d expected %0d", out_cyc[W-1] - out_cyc[0], W - 1); else n_pass++;
    end
    n_checks++; if (n_ls_bad !== 0 || n_ls !== L) $display("FAIL datapath line_start: got %0d (misplaced %0d) expected %0d", n_ls, n_ls_bad, L); else n_pass++;
  endtask

  task automatic test_abort();
    bit found;
    bit ok;
    tick();
    hold_occ = 1'b1; occ_base = 8;
    start_frame();
    wait_read_on_line(12'd1, 80, found);
    n_checks++; if (!found) $display("FAIL abort reach_line1: got no read on line 1 expected one"); else n_pass++;
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    sample();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL abort busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if (bus.buf_rd_en_o !== 1'b0) $display("FAIL abort rd_en: got %b expected 0", bus.buf_rd_en_o); else n_pass++;
    n_checks++; if (bus.slm_valid_o !== 1'b1) $display("FAIL abort in_flight_valid: got %b expected 1", bus.slm_valid_o); else n_pass++;
    repeat (5) sample();
    n_checks++; if (n_rd !== W + 2) $display("FAIL abort reads: got %0d expected %0d", n_rd, W + 2); else n_pass++;
    n_checks++; if (n_ld !== 1 || n_fd !== 0) $display("FAIL abort pulses: got line_done=%0d frame_done=%0d expected 1/0", n_ld, n_fd); else n_pass++;
    n_checks++; if (out_q.size() !== W + 2) $display("FAIL abort words_out: got %0d expected %0d", out_q.size(), W + 2); else n_pass++;
    // abort together with a start request in IDLE must not block the start
    tick();
    epoch++;
    mon_clear++;
    abort_i = 1'b1; enable_i = 1'b1; next_frame_rdy_i = 1'b1;
    tick();
    abort_i = 1'b0; enable_i = 1'b0; next_frame_rdy_i = 1'b0;
    sample();
    n_checks++; if (busy_o !== 1'b1) $display("FAIL abort_in_idle busy: got %b expected 1", busy_o); else n_pass++;
    wait_fd(1, 80, ok);
    n_checks++; if (!ok || n_ld !== L) $display("FAIL abort_in_idle frame: got done=%0d lines=%0d expected 1/%0d", ok, n_ld, L); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    bit ok;
    logic [DW+18:0] outs;
    tick();
    hold_occ = 1'b1; occ_base = 8;
    start_frame();
    wait_read_on_line(12'd2, 80, found);
    n_checks++; if (!found) $display("FAIL midreset reach_line2: got no read on line 2 expected one"); else n_pass++;
    #2;
    reset_all_n = 1'b0;
    #1;
    outs = {bus.buf_rd_en_o, bus.slm_valid_o, bus.slm_line_start_o, line_done_o,
            frame_done_o, busy_o, line_count_o, bus.slm_data_o};
    n_checks++; if (outs !== '0) $display("FAIL midreset async_clear: got %0h expected 0", outs); else n_pass++;
    tick();
    tick();
    reset_all_n = 1'b1;
    sample();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL midreset idle_after: got %b expected 0", busy_o); else n_pass++;
    tick();
    word_base = $urandom;
    start_frame();
    wait_fd(1, 80, ok);
    n_checks++; if (!ok || n_ld !== L || n_rd !== L * W) $display("FAIL midreset fresh_frame: got done=%0d lines=%0d reads=%0d expected 1/%0d/%0d", ok, n_ld, n_rd, L, L * W); else n_pass++;
    n_checks++; if (lc_q.size() == 0 || lc_q[0] !== 12'd0) $display("FAIL midreset first_line: got %0d entries expected line 0 first", lc_q.size()); else n_pass++;
    n_checks++; if (out_q.size() == 0 || out_q[0] !== word_base) $display("FAIL midreset first_word: got %0d entries expected %0h first", out_q.size(), word_base); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int delta;
    tick();
    hold_occ = 1'b1; occ_base = 8;
    epoch++;
    mon_clear++;
    enable_i = 1'b1; next_frame_rdy_i = 1'b1;
    wait_fd(1, 80, ok);
    n_checks++; if (!ok) $display("FAIL b2b first_frame: got no frame_done expected one"); else n_pass++;
    for (int i = 0; i < 8 && rd_rise_q.size() < L + 1; i++) sample();
    delta = (rd_rise_q.size() > L && fd_cyc_q.size() > 0) ? rd_rise_q[L] - fd_cyc_q[0] : -1;
    n_checks++; if (delta < 1 || delta > 3) $display("FAIL b2b restart_latency: got %0d cycles expected 1..3", delta); else n_pass++;
    // Dropping the start qualifiers mid-frame must not stop the frame.
    enable_i = 1'b0; next_frame_rdy_i = 1'b0;
    wait_fd(2, 120, ok);
    n_checks++; if (!ok || n_fd !== 2) $display("FAIL b2b second_frame: got %0d frame_done expected 2", n_fd); else n_pass++;
    n_checks++; if (n_ld !== 2 * L || n_rd !== 2 * L * W) $display("FAIL b2b totals: got lines=%0d reads=%0d expected %0d/%0d", n_ld, n_rd, 2 * L, 2 * L * W); else n_pass++;
    n_checks++; if (lc_q.size() < 2 * L || lc_q[L] !== 12'd0 || lc_q[2*L-1] !== 12'(L - 1)) $display("FAIL b2b line_count_restart: got %0d samples expected second frame 0..%0d", lc_q.size(), L - 1); else n_pass++;
    repeat (4) sample();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL b2b idle_after: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    for (int f = 0; f < 6; f++) begin
      tick();
      hold_occ  = 1'b0;
      refill    = 1'b1;
      occ_base  = $urandom_range(8);
      word_base = $urandom;
      start_frame();
      // Only one start qualifier toggles, so no new frame can be launched.
      enable_i = 1'($urandom_range(1));
      wait_fd(1, 400, ok);
      enable_i = 1'b0;
      n_checks++; if (!ok || n_rd !== L * W || n_ld !== L) $display("FAIL random[%0d] frame: got done=%0d reads=%0d lines=%0d expected 1/%0d/%0d", f, ok, n_rd, n_ld, L * W, L); else n_pass++;
      n_checks++; if (n_gate_bad !== 0 || n_empty_rd !== 0) $display("FAIL random[%0d] gating: got early=%0d empty=%0d expected 0/0", f, n_gate_bad, n_empty_rd); else n_pass++;
      bad = (out_q.size() == L * W) ? 0 : 1;
      for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== word_base + DW'(i)) bad++;
      n_checks++; if (bad !== 0) $display("FAIL random[%0d] data: got %0d bad words of %0d expected 0", f, bad, out_q.size()); else n_pass++;
      bad = (lc_q.size() == L) ? 0 : 1;
      for (int i = 0; i < lc_q.size(); i++) if (lc_q[i] !== 12'(i)) bad++;
      n_checks++; if (bad !== 0) $display("FAIL random[%0d] line_count: got %0d bad samples expected 0", f, bad); else n_pass++;
      repeat ($urandom_range(5)) tick();
    end
    refill   = 1'b0;
    hold_occ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_starvation();
    test_datapath();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
